// File: rtl/mmc1_pkg.sv
// Shared definitions for the MMC1 serial loader.
//   - Register-select encodings as driven on {A14,A13}.
//   - Power-on value of the MMC1 control register (PRG mode 3).
//   - Loader FSM state encoding, also exported on the debug state port.
package mmc1_pkg;

    localparam logic [1:0] REG_CONTROL = 2'd0;
    localparam logic [1:0] REG_CHR0    = 2'd1;
    localparam logic [1:0] REG_CHR1    = 2'd2;
    localparam logic [1:0] REG_PRG     = 2'd3;

    localparam logic [4:0] CTRL_RESET_VALUE = 5'b01100;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RSTW = 3'd1,
        BIT  = 3'd2,
        GAP  = 3'd3,
        FIN  = 3'd4
    } state_t;

endpackage

// File: rtl/mmc1_m2_gen.sv
// Free-running M2 generator.
//   clk, rst     : system clock, asynchronous active-high reset
//   cpu_m2       : M2 clock, low for counts 0..M2_DIV-1, high for the rest
//   cycle_start  : phase count is 0 (first CLK of a bus cycle)
//   cycle_end    : phase count is 2*M2_DIV-1 (last CLK of a bus cycle)
//   high_phase   : M2-high half of the bus cycle
module mmc1_m2_gen #(
    parameter int M2_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic cpu_m2,
    output logic cycle_start,
    output logic cycle_end,
    output logic high_phase
);

    localparam int CW = $clog2(2 * M2_DIV);
    localparam logic [CW-1:0] LAST = CW'(2 * M2_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(M2_DIV);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign high_phase  = (cnt >= HALF);
    assign cpu_m2      = high_phase;
    assign cycle_start = (cnt == '0);
    assign cycle_end   = (cnt == LAST);

endmodule

// File: rtl/mmc1_serial_loader.sv
// Host-side sequencer that programs an MMC1 mapper through its serial port.
// Two requesters post {register, 5-bit value, optional shift reset}; requests
// are arbitrated round-robin and serialised as MMC1 CPU write cycles.
//   CLK, RST                 : clock, asynchronous active-high reset
//   REQx_VALID/READY         : request handshake (see below)
//   REQx_REG/DATA/RST        : register select, value, D7 reset write first
//   CPU_M2 .. CPU_D7         : generated 6502-style bus
//   BUSY                     : request in progress (write or gap cycles)
//   DONE, DONE_ID            : one-CLK completion pulse and its requester
//   DBG_STATE                : current FSM state
//
// Handshake: a requester raises VALID with REG/DATA/RST stable and holds it.
// READY is a single-CLK pulse in the last CLK of an idle M2 cycle; the fields
// are captured on that edge and may change afterwards. Dropping VALID before
// READY withdraws the request.
import mmc1_pkg::*;

module mmc1_serial_loader #(
    parameter int M2_DIV  = 4,
    parameter int GAP_CYC = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ0_VALID,
    output logic       REQ0_READY,
    input  logic [1:0] REQ0_REG,
    input  logic [4:0] REQ0_DATA,
    input  logic       REQ0_RST,
    input  logic       REQ1_VALID,
    output logic       REQ1_READY,
    input  logic [1:0] REQ1_REG,
    input  logic [4:0] REQ1_DATA,
    input  logic       REQ1_RST,
    output logic       CPU_M2,
    output logic       nCPU_ROMSEL,
    output logic       nCPU_RW,
    output logic       CPU_A14,
    output logic       CPU_A13,
    output logic       CPU_D0,
    output logic       CPU_D7,
    output logic       BUSY,
    output logic       DONE,
    output logic       DONE_ID,
    output logic [2:0] DBG_STATE
);

    logic cycle_start, cycle_end, high_phase;

    mmc1_m2_gen #(.M2_DIV(M2_DIV)) u_m2_gen (
        .clk         (CLK),
        .rst         (RST),
        .cpu_m2      (CPU_M2),
        .cycle_start (cycle_start),
        .cycle_end   (cycle_end),
        .high_phase  (high_phase)
    );

    state_t     state, state_nx;
    logic       last_q;       // requester served most recently
    logic       id_q;         // requester being served
    logic [1:0] reg_q;
    logic [4:0] data_q;
    logic [2:0] bit_q;
    logic [3:0] gap_q;
    logic       rstw_gap_q;   // current gap follows the D7 reset write
    logic       hold_q;       // previous cycle was a write: hold bus one CLK
    logic       hold_d7_q;    // ...and that write was the reset write

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

    // Arbitration happens only in the last CLK of an idle M2 cycle, so the
    // first write lands exactly on the next phase count 0.
    logic arb_win, win_id, win_rst;
    assign arb_win = (state == IDLE) && cycle_end && (REQ0_VALID || REQ1_VALID);
    assign win_id  = (REQ0_VALID && REQ1_VALID) ? ~last_q : REQ1_VALID;
    assign win_rst = win_id ? REQ1_RST : REQ0_RST;

    assign REQ0_READY = arb_win && !win_id;
    assign REQ1_READY = arb_win &&  win_id;

    logic is_write, gap_last;
    assign is_write = (state == RSTW) || (state == BIT);
    assign gap_last = (gap_q == GAP_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (arb_win) state_nx = win_rst ? RSTW : BIT;
            RSTW: if (cycle_end) state_nx = GAP;
            BIT:  if (cycle_end) state_nx = GAP;
            GAP: begin
                if (cycle_end && gap_last) begin
                    state_nx = (!rstw_gap_q && bit_q == 3'd4) ? FIN : BIT;
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_q     <= 1'b1;
            id_q       <= 1'b0;
            reg_q      <= 2'd0;
            data_q     <= 5'd0;
            bit_q      <= 3'd0;
            gap_q      <= 4'd0;
            rstw_gap_q <= 1'b0;
            hold_q     <= 1'b0;
            hold_d7_q  <= 1'b0;
        end else begin
            hold_q    <= is_write && cycle_end;
            hold_d7_q <= (state == RSTW) && cycle_end;
            if (arb_win) begin
                id_q   <= win_id;
                last_q <= win_id;
                reg_q  <= win_id ? REQ1_REG  : REQ0_REG;
                data_q <= win_id ? REQ1_DATA : REQ0_DATA;
                bit_q  <= 3'd0;
            end
            if (is_write && cycle_end) begin
                gap_q      <= 4'd0;
                rstw_gap_q <= (state == RSTW);
            end
            if (state == GAP && cycle_end) begin
                gap_q <= gap_q + 4'd1;
                // Bit 0 follows the reset write; otherwise advance, never past 4.
                if (gap_last && !rstw_gap_q && bit_q != 3'd4) begin
                    bit_q <= bit_q + 3'd1;
                end
            end
        end
    end

    // Address, data and RW stay driven for one CLK past the M2 falling edge
    // (the hold window) so the mapper latches stable values. ROMSEL is
    // decoded from the M2-high phase only and releases with M2.
    logic wr_hold, drive, d7_now;
    assign wr_hold = hold_q && cycle_start;
    assign drive   = is_write || wr_hold;
    assign d7_now  = (state == RSTW) || (wr_hold && hold_d7_q);

    assign nCPU_RW     = ~drive;
    assign nCPU_ROMSEL = ~(is_write && high_phase);
    assign CPU_A14     = reg_q[1];
    assign CPU_A13     = reg_q[0];
    assign CPU_D7      = d7_now;
    assign CPU_D0      = drive && !d7_now && data_q[bit_q];

    assign BUSY      = is_write || (state == GAP);
    assign DONE      = (state == FIN);
    assign DONE_ID   = (state == FIN) && id_q;
    assign DBG_STATE = state;

endmodule

// File: tb/tb_mmc1_serial_loader.sv
import mmc1_pkg::*;

module tb_mmc1_serial_loader;

    localparam int M2_DIV  = 4;
    localparam int GAP_CYC = 1;
    localparam int WR_PERIOD = 2 * M2_DIV * (1 + GAP_CYC);

    logic       CLK, RST;
    logic       REQ0_VALID, REQ0_READY, REQ0_RST;
    logic [1:0] REQ0_REG;
    logic [4:0] REQ0_DATA;
    logic       REQ1_VALID, REQ1_READY, REQ1_RST;
    logic [1:0] REQ1_REG;
    logic [4:0] REQ1_DATA;
    logic       CPU_M2, nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D0, CPU_D7;
    logic       BUSY, DONE, DONE_ID;
    logic [2:0] DBG_STATE;

    mmc1_serial_loader #(.M2_DIV(M2_DIV), .GAP_CYC(GAP_CYC)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_REG(REQ0_REG),
        .REQ0_DATA(REQ0_DATA), .REQ0_RST(REQ0_RST),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_REG(REQ1_REG),
        .REQ1_DATA(REQ1_DATA), .REQ1_RST(REQ1_RST),
        .CPU_M2(CPU_M2), .nCPU_ROMSEL(nCPU_ROMSEL), .nCPU_RW(nCPU_RW),
        .CPU_A14(CPU_A14), .CPU_A13(CPU_A13), .CPU_D0(CPU_D0), .CPU_D7(CPU_D7),
        .BUSY(BUSY), .DONE(DONE), .DONE_ID(DONE_ID), .DBG_STATE(DBG_STATE)
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    // ---------------- counters / check ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard: expected writes {D7,A14,A13,D0} ----------------
    logic [3:0] exp_q[$];
    int         wr_cyc[$];
    logic [1:0] q_reg[2];
    logic [4:0] q_data[2];
    logic       q_rst[2];

    task automatic push_exp(int id);
        if (q_rst[id]) exp_q.push_back({1'b1, q_reg[id], 1'b0});
        for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, q_reg[id], q_data[id][i]});
    endtask

    // ---------------- MMC1 mapper model ----------------
    logic [4:0] m_shift = 5'b10000;
    logic [4:0] m_ctrl  = CTRL_RESET_VALUE;
    logic [4:0] m_prg   = 5'd0;

    task automatic mapper_write(logic [3:0] w);
        logic complete;
        if (w[3]) begin
            m_shift = 5'b10000;
            m_ctrl  = m_ctrl | 5'b01100;
        end else begin
            complete = m_shift[0];
            m_shift  = {w[0], m_shift[4:1]};
            if (complete) begin
                if (w[2:1] == REG_CONTROL) m_ctrl = m_shift;
                if (w[2:1] == REG_PRG)     m_prg  = m_shift;
                m_shift = 5'b10000;
            end
        end
    endtask

    function automatic logic [3:0] prg_bank(logic a14);
        case (m_ctrl[3:2])
            2'b11:   return a14 ? 4'hF : m_prg[3:0];
            2'b10:   return a14 ? m_prg[3:0] : 4'h0;
            default: return {m_prg[3:1], a14};
        endcase
    endfunction

    // ---------------- bus monitor ----------------
    logic       prev_rs = 1'b1, prev_m2 = 1'b0, wr_open = 1'b0, idle_chk = 1'b0;
    logic       have_last = 1'b0, r1_seen = 1'b0;
    logic [3:0] cur;
    int         last_wr = 0, done_cnt = 0;

    always @(negedge CLK) begin
        if (RST) begin
            prev_rs = 1'b1; prev_m2 = 1'b0; wr_open = 1'b0; idle_chk = 1'b0; have_last = 1'b0;
        end else begin
            if (DONE) done_cnt++;
            if (REQ1_READY) r1_seen = 1'b1;
            if (!nCPU_ROMSEL) chk("romsel_only_m2_high", CPU_M2, 1'b1);
            if (idle_chk) begin
                chk("bus_idle_after_hold", {nCPU_RW, CPU_D7, CPU_D0}, 3'b100);
                idle_chk = 1'b0;
            end
            if (wr_open && prev_m2 && !CPU_M2) begin
                chk("hold_across_m2_fall", {nCPU_RW, CPU_D7, CPU_A14, CPU_A13, CPU_D0}, {1'b0, cur});
                wr_open  = 1'b0;
                idle_chk = 1'b1;
            end
            if (!nCPU_ROMSEL && prev_rs) begin
                cur = {CPU_D7, CPU_A14, CPU_A13, CPU_D0};
                chk("write_rw_low", nCPU_RW, 1'b0);
                if (have_last) chk("write_spacing", (cyc - last_wr) >= WR_PERIOD, 1'b1);
                chk("write_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) chk("write_fields", cur, exp_q.pop_front());
                mapper_write(cur);
                wr_cyc.push_back(cyc);
                last_wr = cyc; have_last = 1'b1; wr_open = 1'b1;
            end
            prev_rs = nCPU_ROMSEL;
            prev_m2 = CPU_M2;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(int id, logic [1:0] r, logic [4:0] d, logic rs, logic v);
        q_reg[id] = r; q_data[id] = d; q_rst[id] = rs;
        if (id == 0) begin
            REQ0_REG = r; REQ0_DATA = d; REQ0_RST = rs; REQ0_VALID = v;
        end else begin
            REQ1_REG = r; REQ1_DATA = d; REQ1_RST = rs; REQ1_VALID = v;
        end
    endtask

    task automatic wait_ready(output int which, output int t);
        which = -1; t = 0;
        for (int i = 0; i < 400 && which < 0; i++) begin
            @(negedge CLK);
            if (REQ0_READY || REQ1_READY) begin
                chk("ready_onehot", {REQ0_READY, REQ1_READY} != 2'b11, 1'b1);
                which = REQ1_READY ? 1 : 0;
                t = cyc;
                push_exp(which);
            end
        end
        chk("ready_seen", which >= 0, 1'b1);
    endtask

    task automatic wait_done(int exp_id, int t_ready, int exp_lat, output int t_done);
        logic got;
        got = 1'b0; t_done = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge CLK);
            if (DONE) begin
                got = 1'b1; t_done = cyc;
                chk("done_latency", cyc - t_ready, exp_lat);
                chk("done_id", DONE_ID, exp_id);
            end
        end
        chk("done_seen", got, 1'b1);
    endtask

    task automatic check_reset_outputs(string tag);
        chk(tag, {CPU_M2, nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D0, CPU_D7,
                  REQ0_READY, REQ1_READY, BUSY, DONE, DONE_ID}, 12'b011_0000_00000);
        chk({tag, "_state"}, DBG_STATE, IDLE);
    endtask

    task automatic pulse_reset();
        @(negedge CLK); RST = 1'b1;
        repeat (3) @(negedge CLK);
        exp_q.delete();
        RST = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    int w, t, td, base, n0;

    initial begin
        RST = 1'b1;
        set_req(0, 2'd0, 5'd0, 1'b0, 1'b0);
        set_req(1, 2'd0, 5'd0, 1'b0, 1'b0);
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset_values");
        RST = 1'b0;

        // PRG <= 0x15 from requester 0: D0 = 1,0,1,0,1, writes 16 CLK apart.
        base = wr_cyc.size();
        set_req(0, REG_PRG, 5'h15, 1'b0, 1'b1);
        wait_ready(w, t);
        chk("t1_winner", w, 0);
        @(negedge CLK); REQ0_VALID = 1'b0;
        chk("t1_busy", BUSY, 1'b1);
        wait_done(0, t, 81, td);
        chk("t1_write_count", wr_cyc.size() - base, 5);
        for (int i = 0; i < 4; i++)
            if (wr_cyc.size() >= base + 5)
                chk("t1_write_period", wr_cyc[base+i+1] - wr_cyc[base+i], WR_PERIOD);

        // Control <= 0x0C with reset write from requester 1 (PRG mode 3).
        set_req(1, REG_CONTROL, 5'h0C, 1'b1, 1'b1);
        wait_ready(w, t);
        chk("t2_winner", w, 1);
        @(negedge CLK); REQ1_VALID = 1'b0;
        wait_done(1, t, 97, td);

        // PRG <= 0x02: mode 3 fixes the upper bank at $C000.
        set_req(0, REG_PRG, 5'h02, 1'b0, 1'b1);
        wait_ready(w, t);
        @(negedge CLK); REQ0_VALID = 1'b0;
        wait_done(0, t, 81, td);
        chk("mapper_prg_a14_0", prg_bank(1'b0), 4'b0010);
        chk("mapper_prg_a14_1", prg_bank(1'b1), 4'b1111);

        // Asynchronous reset during the 3rd bit write.
        base = wr_cyc.size();
        set_req(0, REG_CHR0, 5'h1F, 1'b0, 1'b1);
        wait_ready(w, t);
        @(negedge CLK); REQ0_VALID = 1'b0;
        for (int i = 0; i < 400 && wr_cyc.size() < base + 3; i++) @(negedge CLK);
        chk("t4_third_write_reached", wr_cyc.size() - base, 3);
        RST = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        n0 = done_cnt;
        set_req(0, REG_CONTROL, 5'h0C, 1'b1, 1'b1);
        wait_ready(w, t);
        chk("t4_winner", w, 0);
        @(negedge CLK); REQ0_VALID = 1'b0;
        wait_done(0, t, 97, td);
        repeat (20) @(negedge CLK);
        chk("t4_done_once", done_cnt - n0, 1);

        // Withdrawn request: requester 1 drops VALID while busy.
        r1_seen = 1'b0;
        set_req(0, REG_CHR1, 5'h0A, 1'b0, 1'b1);
        wait_ready(w, t);
        @(negedge CLK); REQ0_VALID = 1'b0;
        set_req(1, REG_PRG, 5'h07, 1'b0, 1'b1);
        repeat (30) @(negedge CLK);
        chk("t5_busy_mid", BUSY, 1'b1);
        REQ1_VALID = 1'b0;
        wait_done(0, t, 81, td);
        repeat (40) @(negedge CLK);
        chk("t5_no_ready1", r1_seen, 1'b0);
        chk("t5_busy_low", BUSY, 1'b0);
        chk("t5_no_pending", exp_q.size(), 0);

        // Round robin after reset: both valid -> 0, then 1, then 0 again.
        pulse_reset();
        set_req(0, REG_PRG, 5'h01, 1'b0, 1'b1);
        set_req(1, REG_CHR1, 5'h03, 1'b0, 1'b1);
        wait_ready(w, t);
        chk("rr_first", w, 0);
        @(negedge CLK); REQ0_VALID = 1'b0;
        wait_done(0, t, 81, td);
        wait_ready(w, t);
        chk("rr_second", w, 1);
        chk("rr_next_window", t - td, 2 * M2_DIV - 1);
        @(negedge CLK); REQ1_VALID = 1'b0;
        wait_done(1, t, 81, td);
        set_req(0, REG_CHR0, 5'h11, 1'b0, 1'b1);
        set_req(1, REG_CHR1, 5'h12, 1'b0, 1'b1);
        wait_ready(w, t);
        chk("rr_third", w, 0);
        @(negedge CLK); REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        wait_done(0, t, 81, td);
        repeat (20) @(negedge CLK);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
